// File: rtl/udp_tx_framer_if.sv
// Handshake/config bundle between the payload source, the UDP TX framer and the IP TX layer.
// master = source/IP-layer side, slave = framer side.
interface udp_tx_framer_if;
  logic [15:0] src_udp_port;
  logic        src_udp_valid;
  logic [15:0] dst_udp_port;
  logic        dst_udp_valid;
  logic [31:0] src_ip;
  logic [31:0] dst_ip;
  logic [7:0]  send_udp_data;
  logic [15:0] send_udp_len;
  logic        send_udp_last;
  logic        send_udp_valid;
  logic        send_udp_ready;
  logic [7:0]  ip_type;
  logic [7:0]  ip_data;
  logic [15:0] ip_len;
  logic        ip_last;
  logic        ip_valid;
  logic        ip_ready;
  logic        len_err;
  logic        busy;

  modport master (
    output src_udp_port, src_udp_valid, dst_udp_port, dst_udp_valid, src_ip, dst_ip,
           send_udp_data, send_udp_len, send_udp_last, send_udp_valid, ip_ready,
    input  send_udp_ready, ip_type, ip_data, ip_len, ip_last, ip_valid, len_err, busy
  );

  modport slave (
    input  src_udp_port, src_udp_valid, dst_udp_port, dst_udp_valid, src_ip, dst_ip,
           send_udp_data, send_udp_len, send_udp_last, send_udp_valid, ip_ready,
    output send_udp_ready, ip_type, ip_data, ip_len, ip_last, ip_valid, len_err, busy
  );
endinterface

// File: rtl/udp_tx_framer.sv
// Store-and-forward UDP TX framer: buffers a whole payload, then emits header, payload, zero pad.
// Optional real checksum: define UDP_CHECKSUM_EN (otherwise the checksum field is 0x0000).
module udp_tx_framer #(
  parameter logic [15:0] P_SRC_UDP_PORT = 16'h8080,
  parameter logic [15:0] P_DST_UDP_PORT = 16'h8080,
  parameter int          P_MIN_PAYLOAD  = 18,
  parameter int          P_FIFO_DEPTH   = 2048
) (
  input logic            i_clk,
  input logic            i_rst_n,
  udp_tx_framer_if.slave bus
);
  localparam int          AW      = $clog2(P_FIFO_DEPTH);
  localparam logic [15:0] MIN_LEN = 16'(P_MIN_PAYLOAD);
  localparam logic [16:0] MAX_LEN = 17'(P_FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, LOAD, CSUM, HDR, PAY, PAD, DROP} state_t;

  typedef struct packed {
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] len;
    logic [15:0] udp_len;
  } hdr_t;

  state_t         state_q, state_nxt, nsec;
  hdr_t           hdr_q;
  logic [15:0]    src_port_q, dst_port_q;
  logic [15:0]    cnt_q, npos_q, csum_q, ip_len_q, len_in_udp;
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
  logic [7:0]     mem [P_FIFO_DEPTH];
  logic [7:0]     mem_rd, nbyte, data_q;
  logic           ready_q, valid_q, last_q, err_q;
  logic           beat, out_acc, first, wr_en, err_set, frame_done, load_out, rd_adv, nlast, len_bad;

  assign beat       = bus.send_udp_valid && ready_q;
  assign out_acc    = valid_q && bus.ip_ready;
  assign len_bad    = (bus.send_udp_len == 16'd0) || ({1'b0, bus.send_udp_len} > MAX_LEN);
  assign len_in_udp = ((bus.send_udp_len < MIN_LEN) ? MIN_LEN : bus.send_udp_len) + 16'd8;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      src_port_q <= P_SRC_UDP_PORT;
      dst_port_q <= P_DST_UDP_PORT;
    end else begin
      if (bus.src_udp_valid) src_port_q <= bus.src_udp_port;
      if (bus.dst_udp_valid) dst_port_q <= bus.dst_udp_port;
    end
  end

  // Source of the next output byte, selected by its position in the datagram.
  always_comb begin
    nsec  = PAD;
    nbyte = 8'h00;
    if (npos_q < 16'd8) begin
      nsec = HDR;
      case (npos_q[2:0])
        3'd0:    nbyte = hdr_q.src_port[15:8];
        3'd1:    nbyte = hdr_q.src_port[7:0];
        3'd2:    nbyte = hdr_q.dst_port[15:8];
        3'd3:    nbyte = hdr_q.dst_port[7:0];
        3'd4:    nbyte = hdr_q.udp_len[15:8];
        3'd5:    nbyte = hdr_q.udp_len[7:0];
        3'd6:    nbyte = csum_q[15:8];
        default: nbyte = csum_q[7:0];
      endcase
    end else if (npos_q < hdr_q.len + 16'd8) begin
      nsec  = PAY;
      nbyte = mem_rd;
    end
  end

  assign nlast = (npos_q == hdr_q.udp_len - 16'd1);

  always_comb begin
    state_nxt  = state_q;
    first      = 1'b0;
    wr_en      = 1'b0;
    err_set    = 1'b0;
    frame_done = 1'b0;
    load_out   = 1'b0;
    unique case (state_q)
      IDLE: if (beat) begin
        first = 1'b1;
        if (len_bad) begin
          if (bus.send_udp_last) err_set = 1'b1;
          else                   state_nxt = DROP;
        end else begin
          wr_en = 1'b1;
          if (!bus.send_udp_last)              state_nxt = LOAD;
          else if (bus.send_udp_len == 16'd1) state_nxt = CSUM;
          else begin
            err_set    = 1'b1;
            frame_done = 1'b1;
          end
        end
      end
      LOAD: if (beat) begin
        // Beats past the declared length are discarded; the count then can never match.
        wr_en = (cnt_q != hdr_q.len);
        if (bus.send_udp_last) begin
          if (cnt_q + 16'd1 == hdr_q.len) state_nxt = CSUM;
          else begin
            err_set    = 1'b1;
            frame_done = 1'b1;
            state_nxt  = IDLE;
          end
        end
      end
      CSUM: begin
        load_out  = 1'b1;
        state_nxt = nsec;
      end
      HDR, PAY, PAD: if (out_acc) begin
        if (last_q) begin
          frame_done = 1'b1;
          state_nxt  = IDLE;
        end else begin
          load_out  = 1'b1;
          state_nxt = nsec;
        end
      end
      DROP: if (beat && bus.send_udp_last) begin
        err_set   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rd_adv     = load_out && (nsec == PAY);
  assign rd_ptr_nxt = frame_done ? '0 : rd_ptr_q + AW'(rd_adv);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      hdr_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      npos_q   <= '0;
      data_q   <= '0;
      last_q   <= 1'b0;
      valid_q  <= 1'b0;
      ip_len_q <= '0;
    end else begin
      state_q  <= state_nxt;
      ready_q  <= (state_nxt == IDLE) || (state_nxt == LOAD) || (state_nxt == DROP);
      err_q    <= err_set;
      rd_ptr_q <= rd_ptr_nxt;
      if (first)
        hdr_q <= '{src_port: src_port_q, dst_port: dst_port_q,
                   len: bus.send_udp_len, udp_len: len_in_udp};
      if (frame_done) begin
        wr_ptr_q <= '0;
        cnt_q    <= '0;
      end else if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        cnt_q    <= cnt_q + 16'd1;
      end
      if (state_q == CSUM) ip_len_q <= hdr_q.udp_len;
      if (load_out) begin
        data_q  <= nbyte;
        last_q  <= nlast;
        valid_q <= 1'b1;
        npos_q  <= npos_q + 16'd1;
      end else if (frame_done) begin
        data_q   <= '0;
        last_q   <= 1'b0;
        valid_q  <= 1'b0;
        npos_q   <= '0;
        ip_len_q <= '0;
      end
    end
  end

  // Lookahead read: mem_rd always holds mem[rd_ptr_q], so PAY streams without bubbles.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr_q] <= bus.send_udp_data;
    mem_rd <= mem[rd_ptr_nxt];
  end

`ifdef UDP_CHECKSUM_EN
  logic [31:0] acc_q, hdr_sum, byte_term;
  logic [16:0] fold1;
  logic [15:0] fold2, fold_cs;

  // Pseudo-header plus UDP header (checksum 0); UDP length appears in both.
  always_comb begin
    hdr_sum = 32'(bus.src_ip[31:16]) + 32'(bus.src_ip[15:0]) +
              32'(bus.dst_ip[31:16]) + 32'(bus.dst_ip[15:0]) + 32'h0000_0011 +
              32'(len_in_udp) + 32'(len_in_udp) + 32'(src_port_q) + 32'(dst_port_q);
    byte_term = cnt_q[0] ? {24'h0, bus.send_udp_data} : {16'h0, bus.send_udp_data, 8'h00};
    fold1     = {1'b0, acc_q[15:0]} + {1'b0, acc_q[31:16]};
    fold2     = fold1[15:0] + {15'h0, fold1[16]};
    fold_cs   = ~fold2;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_q  <= '0;
      csum_q <= '0;
    end else begin
      if (first)      acc_q <= hdr_sum + (wr_en ? byte_term : 32'h0);
      else if (wr_en) acc_q <= acc_q + byte_term;
      if (state_q == CSUM) csum_q <= (fold_cs == 16'h0000) ? 16'hFFFF : fold_cs;
    end
  end
`else
  assign csum_q = 16'h0000;
`endif

  assign bus.send_udp_ready = ready_q;
  assign bus.ip_type        = 8'd17;
  assign bus.ip_data        = data_q;
  assign bus.ip_len         = ip_len_q;
  assign bus.ip_last        = last_q;
  assign bus.ip_valid       = valid_q;
  assign bus.len_err        = err_q;
  assign bus.busy           = (state_q != IDLE);
endmodule

// File: tb/tb_udp_tx_framer.sv
// Scoreboard bench for udp_tx_framer: expected datagram bytes are queued when a frame is driven.
module tb_udp_tx_framer;
  localparam int MIN_PAY = 18;
  localparam int DEPTH   = 2048;
`ifdef UDP_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0]  data;
    logic        last;
    logic [15:0] ulen;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  udp_tx_framer_if bus();

  udp_tx_framer #(
    .P_SRC_UDP_PORT(16'h8080),
    .P_DST_UDP_PORT(16'h8080),
    .P_MIN_PAYLOAD (MIN_PAY),
    .P_FIFO_DEPTH  (DEPTH)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  exp_t        sb[$];
  exp_t        mon_e;
  int          nvec = 0, nerr = 0;
  int          err_seen = 0, err_exp = 0;
  int          pos = 0, stalls = 0;
  bit          tog = 1'b0;
  bit          hold_pend = 1'b0;
  logic [7:0]  hold_data;
  logic        hold_last;
  logic [15:0] cap_cs;
  logic [15:0] sport_m = 16'h8080, dport_m = 16'h8080;
  logic [31:0] sip_m = 32'hC0A8010A, dip_m = 32'hC0A80114;
  logic [7:0]  pay [0:2099];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_csum(input int len, input logic [15:0] ulen);
    logic [31:0] s;
    logic [15:0] w, cs;
    s = 32'(sip_m[31:16]) + 32'(sip_m[15:0]) + 32'(dip_m[31:16]) + 32'(dip_m[15:0])
      + 32'd17 + 32'(ulen) + 32'(sport_m) + 32'(dport_m) + 32'(ulen);
    for (int i = 0; i < len; i += 2) begin
      w = {pay[i], (i + 1 < len) ? pay[i+1] : 8'h00};
      s = s + 32'(w);
    end
    while (s[31:16] != 16'h0) s = 32'(s[15:0]) + 32'(s[31:16]);
    cs = ~s[15:0];
    if (cs == 16'h0000) cs = 16'hFFFF;
    return CSUM_EN ? cs : 16'h0000;
  endfunction

  task automatic push_frame(input int len);
    int          plen, tot;
    logic [15:0] ul, cs;
    logic [63:0] h;
    exp_t        e;
    plen = (len < MIN_PAY) ? MIN_PAY : len;
    tot  = plen + 8;
    ul   = 16'(tot);
    cs   = model_csum(len, ul);
    h    = {sport_m, dport_m, ul, cs};
    for (int i = 0; i < tot; i++) begin
      if (i < 8)            e.data = h[63 - 8*i -: 8];
      else if (i - 8 < len) e.data = pay[i-8];
      else                  e.data = 8'h00;
      e.last = (i == tot - 1);
      e.ulen = ul;
      sb.push_back(e);
    end
  endtask

  task automatic send(input int len, input int nbeats, input bit lat);
    int t;
    for (int i = 0; i < nbeats; i++) begin
      bus.send_udp_data  = pay[i];
      bus.send_udp_len   = 16'(len);
      bus.send_udp_last  = (i == nbeats - 1);
      bus.send_udp_valid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!bus.send_udp_ready && t < 200) begin
        stalls++;
        t++;
        @(negedge clk);
      end
      if (t >= 200) begin
        chk("beat_timeout", 32'(t), 32'd0);
        break;
      end
      @(posedge clk); #1;
    end
    bus.send_udp_valid = 1'b0;
    bus.send_udp_last  = 1'b0;
    if (lat) begin
      @(negedge clk);
      chk("lat_csum_cycle", 32'(bus.ip_valid), 32'd0);
      @(negedge clk);
      chk("lat_first_hdr", {23'h0, bus.ip_valid, bus.ip_data}, {23'h0, 1'b1, sport_m[15:8]});
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    while ((sb.size() != 0 || bus.busy) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("done_timeout", 32'(t < 5000), 32'd1);
    repeat (3) @(negedge clk);
    chk(tag, 32'(err_seen), 32'(err_exp));
    @(posedge clk); #1;
  endtask

  task automatic set_ports(input logic [15:0] sp, input logic [15:0] dp);
    bus.src_udp_port  = sp;
    bus.dst_udp_port  = dp;
    bus.src_udp_valid = 1'b1;
    bus.dst_udp_valid = 1'b1;
    @(posedge clk); #1;
    bus.src_udp_valid = 1'b0;
    bus.dst_udp_valid = 1'b0;
    sport_m = sp;
    dport_m = dp;
  endtask

  initial begin
    bus.ip_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.ip_ready = tog ? ~bus.ip_ready : 1'b1;
    end
  end

  // Output monitor: every accepted byte is popped and compared; stalled bytes must hold.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      hold_pend = 1'b0;
      pos       = 0;
    end else begin
      if (bus.len_err) err_seen++;
      if (hold_pend)
        chk("hold", {22'h0, bus.ip_valid, bus.ip_last, bus.ip_data}, {22'h0, 1'b1, hold_last, hold_data});
      hold_pend = 1'b0;
      if (bus.ip_valid) begin
        if (!bus.ip_ready) begin
          hold_pend = 1'b1;
          hold_data = bus.ip_data;
          hold_last = bus.ip_last;
        end else if (sb.size() == 0) begin
          chk("spurious_valid", 32'(bus.ip_valid), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("data", 32'(bus.ip_data), 32'(mon_e.data));
          chk("last", 32'(bus.ip_last), 32'(mon_e.last));
          chk("ip_len", 32'(bus.ip_len), 32'(mon_e.ulen));
          if (pos == 6) cap_cs[15:8] = bus.ip_data;
          if (pos == 7) cap_cs[7:0]  = bus.ip_data;
          pos = bus.ip_last ? 0 : pos + 1;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int t;
    bus.src_udp_port   = 16'h0;
    bus.src_udp_valid  = 1'b0;
    bus.dst_udp_port   = 16'h0;
    bus.dst_udp_valid  = 1'b0;
    bus.src_ip         = sip_m;
    bus.dst_ip         = dip_m;
    bus.send_udp_data  = 8'h0;
    bus.send_udp_len   = 16'h0;
    bus.send_udp_last  = 1'b0;
    bus.send_udp_valid = 1'b0;

    #12;
    chk("rst_ready", 32'(bus.send_udp_ready), 32'd0);
    chk("rst_valid", 32'(bus.ip_valid), 32'd0);
    chk("rst_busy",  32'(bus.busy), 32'd0);
    chk("rst_err",   32'(bus.len_err), 32'd0);
    chk("rst_len",   32'(bus.ip_len), 32'd0);
    chk("rst_type",  32'(bus.ip_type), 32'd17);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", 32'(bus.send_udp_ready), 32'd1);

    // len=2 -> 26-byte datagram with 16 pad bytes
    pay[0] = 8'h01; pay[1] = 8'h02;
    push_frame(2);
    send(2, 2, 1'b1);
    wait_done("err_len2");
    chk("csum_vec", 32'(cap_cs), CSUM_EN ? 32'h7A48 : 32'h0000);

    // len=40, no padding; then same frame under toggling backpressure
    for (int i = 0; i < 40; i++) pay[i] = 8'(i);
    push_frame(40);
    send(40, 40, 1'b1);
    wait_done("err_len40");
    tog = 1'b1;
    push_frame(40);
    send(40, 40, 1'b0);
    wait_done("err_len40_bp");
    tog = 1'b0;

    // short frame: last on 7th of 10
    err_exp++;
    send(10, 7, 1'b0);
    wait_done("err_short");

    set_ports(16'h1234, 16'hABCD);
    for (int i = 0; i < 5; i++) pay[i] = 8'($urandom);
    push_frame(5);
    send(5, 5, 1'b0);
    wait_done("err_after_short");

    // zero length (single beat and multi beat), then overlong beats
    err_exp++;
    send(0, 1, 1'b0);
    wait_done("err_len0_single");
    err_exp++;
    send(0, 3, 1'b0);
    wait_done("err_len0_multi");
    err_exp++;
    send(3, 5, 1'b0);
    wait_done("err_overlong");

    // boundaries around the minimum payload and the odd single byte
    for (int i = 0; i < 20; i++) pay[i] = 8'($urandom);
    push_frame(18);
    send(18, 18, 1'b0);
    wait_done("err_len18");
    tog = 1'b1;
    push_frame(17);
    send(17, 17, 1'b0);
    wait_done("err_len17");
    tog = 1'b0;
    push_frame(1);
    send(1, 1, 1'b0);
    wait_done("err_len1");

    // buffer exactly full, then one byte too many
    for (int i = 0; i < DEPTH + 1; i++) pay[i] = 8'($urandom);
    push_frame(DEPTH);
    send(DEPTH, DEPTH, 1'b0);
    wait_done("err_full");
    err_exp++;
    stalls = 0;
    send(DEPTH + 1, DEPTH + 1, 1'b0);
    chk("drop_stalls", 32'(stalls), 32'd0);
    wait_done("err_drop");

    // reset in the middle of the payload
    for (int i = 0; i < 30; i++) pay[i] = 8'($urandom);
    push_frame(30);
    send(30, 30, 1'b0);
    t = 0;
    while (pos < 12 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("reach_pay", 32'(pos >= 12), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(bus.ip_valid), 32'd0);
    chk("midrst_busy",  32'(bus.busy), 32'd0);
    chk("midrst_ready", 32'(bus.send_udp_ready), 32'd0);
    chk("midrst_data",  32'(bus.ip_data), 32'd0);
    sb.delete();
    sport_m = 16'h8080;
    dport_m = 16'h8080;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_busy",  32'(bus.busy), 32'd0);
    chk("post_rst_ready", 32'(bus.send_udp_ready), 32'd1);
    repeat (10) @(posedge clk);
    #1;
    push_frame(30);
    send(30, 30, 1'b0);
    wait_done("err_post_rst");

    chk("err_total", 32'(err_seen), 32'(err_exp));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/udp_tx_framer.md
Name: udp_tx_framer

Overview:
Store-and-forward UDP transmit framer with per-frame header snapshot, zero-padding to a parametrised minimum payload, and ready/valid backpressure on both sides. It sits between the user payload stream and the IP TX layer. It generalises the earlier cut-through UDP TX with these additions:
- FIFO depth parameter
- frame length checking and drop
- IP-side backpressure
- optional real UDP checksum

Parameters:
P_SRC_UDP_PORT, 16'h8080, source port after reset.
P_DST_UDP_PORT, 16'h8080, destination port after reset.
P_MIN_PAYLOAD, 18, minimum payload bytes; shorter payloads are zero-padded.
P_FIFO_DEPTH, 2048, payload buffer bytes; power of 2; address width = clog2(P_FIFO_DEPTH).

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_src_udp_port  in  16  new source port
i_src_udp_valid  in  1  load i_src_udp_port
i_dst_udp_port  in  16  new destination port
i_dst_udp_valid  in  1  load i_dst_udp_port
i_src_ip  in  32  pseudo-header source IP (checksum only)
i_dst_ip  in  32  pseudo-header destination IP (checksum only)
i_send_udp_data  in  8  payload byte
i_send_udp_len  in  16  payload length, sampled on first beat
i_send_udp_last  in  1  final payload beat
i_send_udp_valid  in  1  payload beat valid
o_send_udp_ready  out  1  framer accepts a beat
o_ip_type  out  8  constant 8'd17
o_ip_data  out  8  UDP datagram byte
o_ip_len  out  16  UDP length, stable for the whole output frame
o_ip_last  out  1  final datagram byte
o_ip_valid  out  1  output byte valid
i_ip_ready  in  1  IP layer accepts the byte
o_len_err  out  1  one-cycle pulse: frame dropped
o_busy  out  1  high whenever state is not IDLE

Behaviour:
- Single clock domain. Asynchronous active-low reset.
- Reset values: all outputs 0 except o_ip_type = 17. Port registers load their parameter defaults. FIFO empties, state goes to IDLE.
- Reset asserted mid-frame: the frame is lost. No partial output follows deassertion.
- Port registers update on the respective *_valid at any time. The header uses a snapshot taken on the first accepted beat of each frame.
- Beat accepted = i_send_udp_valid && o_send_udp_ready.
- Output byte accepted = o_ip_valid && i_ip_ready. o_ip_data and o_ip_last stay stable while o_ip_valid=1 && !i_ip_ready.
- State machine:
  - IDLE: ready=1. On first accepted beat: latch len, ports and IPs; write byte; go to LOAD, or to CSUM if last is also set.
  - LOAD: ready=1. Write each accepted byte and count it. On last, go to CSUM.
  - CSUM: one cycle; ready=0; checksum fold. Go to HDR. First header byte is valid exactly 2 cycles after the last beat is accepted.
  - HDR: 8 bytes: src port hi/lo, dst port hi/lo, length hi/lo, checksum hi/lo.
  - PAY: FIFO bytes; prefetch so there are no bubbles while i_ip_ready=1.
  - PAD: zero bytes up to P_MIN_PAYLOAD.
  - DROP: ready=1; discard beats until last.
  - After the final byte is accepted, go to IDLE; ready returns the next cycle.
- Length rule: UDP length = max(len, P_MIN_PAYLOAD) + 8, 16-bit. o_ip_len is driven from HDR entry until the last byte is accepted.
- Error and drop rules (o_len_err pulses once per dropped frame; nothing is output):
  - Latched len = 0: drop the frame.
  - Latched len > P_FIFO_DEPTH: go to DROP.
  - last arrives with beat count != len: pulse o_len_err, reset FIFO pointers, go to IDLE.
  - Beat count reaches len without last: further beats are discarded and count as a mismatch.
- Output ends on o_ip_last with the final byte: the last pad byte, or the last payload byte when len >= P_MIN_PAYLOAD.

Optional Feature:
UDP_CHECKSUM_EN.
- Defined: a running 32-bit one's-complement accumulator sums the following, then CSUM folds carries twice and inverts:
  - pseudo-header: src IP, dst IP, 16'h0011, UDP length
  - UDP header with checksum 0
  - payload as big-endian 16-bit words; an odd trailing byte is padded with 0x00; pad bytes add nothing
  - A result of 0x0000 is sent as 0xFFFF.
- Undefined: checksum field = 0x0000, i_src_ip/i_dst_ip are unused, and the accumulator is removed. CSUM latency is kept, so timing is identical.

Test Plan:
- Default ports, len=2, payload 01 02, i_ip_ready=1 -> o_ip_len=26. Bytes: 80 80 80 80 00 1A, then checksum, 01 02, 16×00, last on byte 26.
- As above with UDP_CHECKSUM_EN, src 192.168.1.10, dst 192.168.1.20 -> checksum bytes 7A 48.
- len=40 payload 0..39 -> o_ip_len=48, no padding, last with byte 0x27; first header valid 2 cycles after last accepted.
- len=40, i_ip_ready toggled 1/0 every cycle -> identical 48-byte sequence with no skipped or duplicated bytes; data held while not ready.
- len=10, last on 7th beat -> o_len_err pulse, no o_ip_valid. Next good frame is output correctly.
- len=P_FIFO_DEPTH+1 -> DROP absorbs every beat (ready=1), one o_len_err pulse. Reset asserted mid-PAY -> outputs 0 immediately, IDLE after release.
